div_sequencer: RTL and testbench

- Multi-cycle sequencer for the hardware division operation, selected when the ALU control code equals 6'h30.
- Sits beside the ALU in the EX stage of the mMIPS pipeline.
- Detects a division request and runs a radix-2 restoring signed divide over WIDTH cycles.
- Stalls the pipeline for the duration, then presents quotient and remainder for one write-back cycle.

---
 rtl/div_sequencer.sv | 140 ++++++++++++++
 tb/tb_div_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring signed divider for the EX stage; stalls the pipeline
// for WIDTH+1 cycles (1 on divide-by-zero) and presents results for one DONE cycle.
module div_sequencer #(
   parameter int         WIDTH    = 32,
   parameter logic [5:0] DIV_CODE = 6'h30
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       ALUctrl,
   input  logic             instr_valid,
   input  logic             flush,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sgnq_q, sgnq_d;
   logic             sgnr_q, sgnr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;

   logic             start;
   logic [WIDTH-1:0] dvd_abs, dvs_abs;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] rem_step, quo_step;

   // Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| is represented exactly.
   always_comb begin
      dvd_abs  = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;
      rem_sh   = {rem_q, quo_q[WIDTH-1]};
      ge       = (rem_sh >= {1'b0, dvs_q});
      rem_step = ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], ge};
   end

   assign start       = (ALUctrl == DIV_CODE) && instr_valid && !flush && (state_q == IDLE);
   assign stall       = start || ((state_q == RUN) && !flush);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      sgnq_d  = sgnq_q;
      sgnr_d  = sgnr_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quot_d  = '0;
                  remo_d  = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = dvd_abs;
                  dvs_d   = dvs_abs;
                  rem_d   = '0;
                  sgnq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sgnr_d  = dividend[WIDTH-1];
                  cnt_d   = CW'(WIDTH);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
               cnt_d = cnt_q - CW'(1);
               // Results are registered on the final iteration so they are valid during DONE.
               if (cnt_q == CW'(1)) begin
                  quot_d  = sgnq_q ? -quo_step : quo_step;
                  remo_d  = sgnr_q ? -rem_step : rem_step;
                  dbz_d   = 1'b0;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sgnq_q  <= 1'b0;
         sgnr_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         sgnq_q  <= sgnq_d;
         sgnr_q  <= sgnr_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: schedule-based reference model checked every cycle,
// directed cases with literal expectations, then randomized divides and aborts.
module tb_div_sequencer;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic [5:0]   ALUctrl;
   logic         instr_valid;
   logic         flush;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         stall;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   always #5 clock = ~clock;

   div_sequencer #(.WIDTH(W), .DIV_CODE(6'h30)) dut (
      .clock       (clock),
      .reset       (reset),
      .ALUctrl     (ALUctrl),
      .instr_valid (instr_valid),
      .flush       (flush),
      .dividend    (dividend),
      .divisor     (divisor),
      .stall       (stall),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Signed divide truncating toward zero; 64-bit arithmetic makes min/-1 wrap naturally.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic z);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == '0) begin
         q = '0;
         r = a;
         z = 1'b1;
      end else begin
         q = W'(sa / sb);
         r = W'(sa % sb);
         z = 1'b0;
      end
   endfunction

   // Model: a request at cycle n yields done at n+W+1 (n+1 for zero divisor), stall in between.
   longint       n       = 0;
   longint       start_c = -1;
   longint       done_c  = -1;
   logic [W-1:0] eq = '0, er = '0, pq = '0, pr = '0;
   logic         ez = 1'b0, pz = 1'b0;

   always @(negedge clock) begin : model
      bit active, in_run, st;
      n++;
      if (armed) begin
         if (n == done_c) begin
            eq = pq;
            er = pr;
            ez = pz;
         end
         active = (start_c < n) && (n <= done_c);
         in_run = (start_c < n) && (n < done_c);
         st     = (ALUctrl == 6'h30) && instr_valid && !flush && !active;
         chk("stall", stall, st || (in_run && !flush));
         chk("done", done, n == done_c);
         chk("quotient", quotient, eq);
         chk("remainder", remainder, er);
         chk("div_by_zero", div_by_zero, ez);
         if (reset) begin
            start_c = -1;
            done_c  = -1;
            eq = '0;
            er = '0;
            ez = 1'b0;
         end else if (in_run && flush) begin
            done_c = -1;
         end else if (st) begin
            start_c = n;
            ref_div(dividend, divisor, pq, pr, pz);
            done_c = n + ((divisor == '0) ? 1 : W + 1);
         end
      end
   end

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int stalls);
      @(posedge clock); #1;
      ALUctrl = 6'h30; instr_valid = 1'b1; flush = 1'b0; dividend = a; divisor = b;
      lat = -1;
      stalls = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (done) begin
            lat = k;
            break;
         end
         if (stall) stalls++;
      end
      chk("done_seen", lat >= 0, 1);
   endtask

   task automatic go_idle(input int cycles, input bit noise, output int dones, output int stalls);
      dones = 0;
      stalls = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clock); #1;
         if (noise) begin
            ALUctrl     = 6'($urandom);
            instr_valid = 1'($urandom);
            flush       = 1'($urandom);
            dividend    = $urandom;
            divisor     = $urandom;
            if (ALUctrl == 6'h30) instr_valid = 1'b0;
         end else begin
            ALUctrl = 6'h00; instr_valid = 1'b0; flush = 1'b0;
         end
         @(negedge clock);
         if (done)  dones++;
         if (stall) stalls++;
      end
      @(posedge clock); #1;
      ALUctrl = 6'h00; instr_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic abort_div(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int k, input bit use_reset);
      @(posedge clock); #1;
      ALUctrl = 6'h30; instr_valid = 1'b1; flush = 1'b0; dividend = a; divisor = b;
      repeat (k) @(posedge clock);
      #1;
      if (use_reset) reset = 1'b1;
      else           flush = 1'b1;
      @(negedge clock);
      if (!use_reset) chk("flush_stall", stall, 0);
      @(posedge clock); #1;
      reset = 1'b0; flush = 1'b0; instr_valid = 1'b0; ALUctrl = 6'h00;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lat, stl, dn, st;
      logic [W-1:0] a, b, prev_q, prev_r;
      logic prev_z;

      reset = 1'b1; ALUctrl = 6'h00; instr_valid = 1'b0; flush = 1'b0;
      dividend = '0; divisor = '0;
      @(posedge clock); #1;
      armed = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);

      run_div(32'd100, 32'd7, lat, stl);
      chk("lat_100_7", lat, 33);
      chk("stalls_100_7", stl, 33);
      chk("q_100_7", quotient, 14);
      chk("r_100_7", remainder, 2);
      chk("z_100_7", div_by_zero, 0);

      run_div(32'hFFFF_FFF9, 32'd2, lat, stl);
      chk("q_m7_2", quotient, 32'hFFFF_FFFD);
      chk("r_m7_2", remainder, 32'hFFFF_FFFF);
      run_div(32'd7, 32'hFFFF_FFFE, lat, stl);
      chk("q_7_m2", quotient, 32'hFFFF_FFFD);
      chk("r_7_m2", remainder, 1);

      run_div(32'h1234, 32'd0, lat, stl);
      chk("lat_dbz", lat, 1);
      chk("stalls_dbz", stl, 1);
      chk("q_dbz", quotient, 0);
      chk("r_dbz", remainder, 32'h1234);
      chk("z_dbz", div_by_zero, 1);
      run_div(32'd9, 32'd3, lat, stl);
      chk("q_9_3", quotient, 3);
      chk("z_9_3", div_by_zero, 0);

      run_div(32'h8000_0000, 32'hFFFF_FFFF, lat, stl);
      chk("q_ovf", quotient, 32'h8000_0000);
      chk("r_ovf", remainder, 0);
      chk("z_ovf", div_by_zero, 0);

      prev_q = quotient; prev_r = remainder; prev_z = div_by_zero;
      abort_div(32'd100, 32'd7, 10, 1'b0);
      go_idle(40, 1'b0, dn, st);
      chk("flush_no_done", dn, 0);
      chk("flush_keep_q", quotient, prev_q);
      chk("flush_keep_r", remainder, prev_r);
      chk("flush_keep_z", div_by_zero, prev_z);

      run_div(32'd100, 32'd0, lat, stl);
      abort_div(32'd100, 32'd7, 10, 1'b1);
      @(negedge clock);
      chk("rstab_q", quotient, 0);
      chk("rstab_r", remainder, 0);
      chk("rstab_z", div_by_zero, 0);
      chk("rstab_stall", stall, 0);
      chk("rstab_done", done, 0);

      run_div(32'd50, 32'd5, lat, stl);
      chk("q_50_5", quotient, 10);
      run_div(32'd50, 32'd6, lat, stl);
      chk("lat_50_6", lat, 33);
      chk("q_50_6", quotient, 8);
      chk("r_50_6", remainder, 2);
      go_idle(40, 1'b0, dn, st);
      chk("b2b_no_third", dn + st, 0);

      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #1;
         ALUctrl = 6'h31; instr_valid = 1'b1; dividend = 32'd100; divisor = 32'd7;
         @(negedge clock);
         chk("nonreq_31", stall, 0);
         @(posedge clock); #1;
         ALUctrl = 6'h30; instr_valid = 1'b0;
         @(negedge clock);
         chk("nonreq_invalid", stall, 0);
      end

      for (int it = 0; it < 60; it++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 9));
            2:       b = -W'($urandom_range(1, 9));
            3:       begin a = 32'h8000_0000; b = (it % 2 == 0) ? 32'hFFFF_FFFF : W'($urandom_range(1, 5)); end
            default: a = W'($urandom_range(0, 1000));
         endcase
         if (b != '0 && $urandom_range(0, 5) == 0) begin
            abort_div(a, b, $urandom_range(1, W), 1'b0);
         end else begin
            run_div(a, b, lat, stl);
            chk("rand_lat", lat, (b == '0) ? 1 : W + 1);
         end
         go_idle($urandom_range(0, 3), 1'b1, dn, st);
      end

      go_idle(5, 1'b0, dn, st);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
